// File: rtl/rv_g_wb_arbiter.sv
// ---------------------------------------------------------------------------
// rv_g_wb_arbiter
//
// Writeback arbiter between the execution units and the unified integer/FP
// register file. Every execution unit pushes results into its own small
// in-order FIFO. Each cycle at most one FIFO head is chosen round-robin and
// registered onto the register file's single write-and-unlock port.
//
// Ports
//   clk_i        : clock
//   arst_ni      : asynchronous reset, active-low
//   src_valid_i  : [NUM_SRC]            result valid per source
//   src_ready_o  : [NUM_SRC]            source FIFO not full
//   src_addr_i   : [NUM_SRC][5:0]       destination (bit 5 set = FP register)
//   src_data_i   : [NUM_SRC][MaxLen-1:0] result data
//   wr_en_o      : register file write-and-unlock enable (registered)
//   wr_addr_o    : register file write address (registered)
//   wr_data_o    : register file write data (registered)
//   busy_o       : any FIFO holds a result or a write is being presented
//
// All wr_* outputs come straight from flops, and src_ready_o depends only on
// FIFO occupancy flops, so no src_* input reaches any output combinationally.
// ---------------------------------------------------------------------------
module rv_g_wb_arbiter #(
  parameter int  NUM_SRC    = 4,
  parameter int  XLEN       = 64,
  parameter int  FLEN       = 32,
  parameter int  FIFO_DEPTH = 2,
  localparam int MaxLen     = (FLEN > XLEN) ? FLEN : XLEN
) (
  input  logic                             clk_i,
  input  logic                             arst_ni,
  input  logic [NUM_SRC-1:0]               src_valid_i,
  output logic [NUM_SRC-1:0]               src_ready_o,
  input  logic [NUM_SRC-1:0][5:0]          src_addr_i,
  input  logic [NUM_SRC-1:0][MaxLen-1:0]   src_data_i,
  output logic                             wr_en_o,
  output logic [5:0]                       wr_addr_o,
  output logic [MaxLen-1:0]                wr_data_o,
  output logic                             busy_o
);

  localparam int IDX_W = $clog2(NUM_SRC);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Masks keep only the architectural width of the destination register file.
  // When a width equals MaxLen the shift is zero and the mask is all ones.
  localparam logic [MaxLen-1:0] FpMask  = {MaxLen{1'b1}} >> (MaxLen - FLEN);
  localparam logic [MaxLen-1:0] IntMask = {MaxLen{1'b1}} >> (MaxLen - XLEN);

  // -------------------------------------------------------------------------
  // Arbitration state and shared per-source views
  // -------------------------------------------------------------------------
  logic [IDX_W-1:0]  rr_ptr_reg;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid;

  logic [NUM_SRC-1:0] fifo_full;
  logic [NUM_SRC-1:0] fifo_empty;
  logic [5:0]         head_addr [NUM_SRC];
  logic [MaxLen-1:0]  head_data [NUM_SRC];

  // -------------------------------------------------------------------------
  // Per-source FIFOs
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_fifo
      logic [5:0]        addr_mem [FIFO_DEPTH];
      logic [MaxLen-1:0] data_mem [FIFO_DEPTH];
      logic [PTR_W-1:0]  wr_ptr_reg;
      logic [PTR_W-1:0]  rd_ptr_reg;
      logic [CNT_W-1:0]  count_reg;
      logic              push;
      logic              pop;
      logic [MaxLen-1:0] in_data;

      assign fifo_full[gi]  = (count_reg == CNT_W'(FIFO_DEPTH));
      assign fifo_empty[gi] = (count_reg == '0);

      // Ready comes from the full flag alone, so a full FIFO cannot refill in
      // the cycle it drains; the slot reopens the cycle after the dequeue.
      assign push = src_valid_i[gi] & ~fifo_full[gi];
      assign pop  = grant_valid & (grant_idx == IDX_W'(gi));

      assign in_data = src_addr_i[gi][5] ? (src_data_i[gi] & FpMask)
                                         : (src_data_i[gi] & IntMask);

      always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          // FIFO_DEPTH is a power of two, so pointers wrap by overflow.
          if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          count_reg <= count_reg + CNT_W'(push) - CNT_W'(pop);
        end
      end

      // Storage needs no reset: the occupancy count decides what is valid.
      always_ff @(posedge clk_i) begin
        if (push) begin
          addr_mem[wr_ptr_reg] <= src_addr_i[gi];
          data_mem[wr_ptr_reg] <= in_data;
        end
      end

      // Head is read asynchronously so a freshly written entry can win in the
      // very next cycle (single-cycle accept-to-write latency).
      assign head_addr[gi] = addr_mem[rd_ptr_reg];
      assign head_data[gi] = data_mem[rd_ptr_reg];

      assign src_ready_o[gi] = ~fifo_full[gi];
    end
  endgenerate

  // -------------------------------------------------------------------------
  // Round-robin pick: first non-empty FIFO after the last winner
  // -------------------------------------------------------------------------
  always_comb begin
    logic [IDX_W:0] cand;
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_reg;
    cand        = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      // rr_ptr + i < 2*NUM_SRC, so one conditional subtract is a full modulo.
      cand = {1'b0, rr_ptr_reg} + (IDX_W + 1)'(i);
      if (cand >= (IDX_W + 1)'(NUM_SRC)) begin
        cand = cand - (IDX_W + 1)'(NUM_SRC);
      end
      if (!grant_valid && !fifo_empty[cand[IDX_W-1:0]]) begin
        grant_valid = 1'b1;
        grant_idx   = cand[IDX_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      // Parked on the last source so source 0 is first after reset.
      rr_ptr_reg <= IDX_W'(NUM_SRC - 1);
    end else if (grant_valid) begin
      rr_ptr_reg <= grant_idx;
    end
  end

  // -------------------------------------------------------------------------
  // Output register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_en_o   <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= '0;
    end else begin
      // A grant of x0 still uses the slot but never asserts the write.
      wr_en_o <= grant_valid && (head_addr[grant_idx] != 6'd0);
      if (grant_valid) begin
        wr_addr_o <= head_addr[grant_idx];
        wr_data_o <= head_data[grant_idx];
      end
    end
  end

  assign busy_o = (~&fifo_empty) | wr_en_o;

endmodule

// File: tb/tb_rv_g_wb_arbiter.sv
module tb_rv_g_wb_arbiter;

  localparam int NUM_SRC = 4;
  localparam int W       = 64;

  logic                       clk_i;
  logic                       arst_ni;
  logic [NUM_SRC-1:0]         src_valid_i;
  logic [NUM_SRC-1:0]         src_ready_o;
  logic [NUM_SRC-1:0][5:0]    src_addr_i;
  logic [NUM_SRC-1:0][W-1:0]  src_data_i;
  logic                       wr_en_o;
  logic [5:0]                 wr_addr_o;
  logic [W-1:0]               wr_data_o;
  logic                       busy_o;

  int vectors;
  int miscompares;

  rv_g_wb_arbiter #(
    .NUM_SRC    (4),
    .XLEN       (64),
    .FLEN       (32),
    .FIFO_DEPTH (2)
  ) dut (
    .clk_i       (clk_i),
    .arst_ni     (arst_ni),
    .src_valid_i (src_valid_i),
    .src_ready_o (src_ready_o),
    .src_addr_i  (src_addr_i),
    .src_data_i  (src_data_i),
    .wr_en_o     (wr_en_o),
    .wr_addr_o   (wr_addr_o),
    .wr_data_o   (wr_data_o),
    .busy_o      (busy_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Advance past one rising edge and settle; outputs are sampled here.
  task automatic tick;
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_inputs;
    src_valid_i = '0;
    src_addr_i  = '0;
    src_data_i  = '0;
  endtask

  task automatic do_reset;
    arst_ni = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk_i);
    #2;
    arst_ni = 1'b1;
  endtask

  task automatic test_reset;
    do_reset();
    vectors++;
    if (src_ready_o !== 4'hF) begin
      miscompares++;
      $display("FAIL reset_ready: got %b want 1111", src_ready_o);
    end
    vectors++;
    if (wr_en_o !== 1'b0 || busy_o !== 1'b0 || wr_addr_o !== 6'd0 || wr_data_o !== 64'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got en=%b busy=%b addr=%0d data=%h want 0/0/0/0",
               wr_en_o, busy_o, wr_addr_o, wr_data_o);
    end
    // src0 -> addr 5, data A5 at edge 0
    src_valid_i[0] = 1'b1;
    src_addr_i[0]  = 6'd5;
    src_data_i[0]  = 64'hA5;
    tick();
    clear_inputs();
    vectors++;
    if (wr_en_o !== 1'b0 || busy_o !== 1'b1) begin
      miscompares++;
      $display("FAIL first_edge0: got en=%b busy=%b want en=0 busy=1", wr_en_o, busy_o);
    end
    tick();
    vectors++;
    if (wr_en_o !== 1'b1 || wr_addr_o !== 6'd5 || wr_data_o !== 64'hA5) begin
      miscompares++;
      $display("FAIL first_write: got en=%b addr=%0d data=%h want 1/5/a5",
               wr_en_o, wr_addr_o, wr_data_o);
    end
    tick();
    vectors++;
    if (wr_en_o !== 1'b0 || busy_o !== 1'b0 || wr_addr_o !== 6'd5) begin
      miscompares++;
      $display("FAIL first_one_cycle: got en=%b busy=%b addr=%0d want 0/0/5",
               wr_en_o, busy_o, wr_addr_o);
    end
    $display("test_reset done");
  endtask

  task automatic test_contention;
    do_reset();
    for (int k = 0; k < NUM_SRC; k++) begin
      src_valid_i[k] = 1'b1;
      src_addr_i[k]  = 6'(k + 1);
      src_data_i[k]  = 64'h100 + 64'(k);
    end
    tick();
    clear_inputs();
    for (int k = 0; k < NUM_SRC; k++) begin
      tick();
      vectors++;
      if (wr_en_o !== 1'b1 || wr_addr_o !== 6'(k + 1) || wr_data_o !== 64'h100 + 64'(k)) begin
        miscompares++;
        $display("FAIL contention_order[%0d]: got en=%b addr=%0d data=%h want 1/%0d/%h",
                 k, wr_en_o, wr_addr_o, wr_data_o, k + 1, 64'h100 + 64'(k));
      end
    end
    // Last winner is src3, so src1 beats src3.
    src_valid_i[3] = 1'b1; src_addr_i[3] = 6'd23; src_data_i[3] = 64'h333;
    src_valid_i[1] = 1'b1; src_addr_i[1] = 6'd21; src_data_i[1] = 64'h111;
    tick();
    clear_inputs();
    tick();
    vectors++;
    if (wr_en_o !== 1'b1 || wr_addr_o !== 6'd21 || wr_data_o !== 64'h111) begin
      miscompares++;
      $display("FAIL rr_src1_first: got en=%b addr=%0d data=%h want 1/21/111",
               wr_en_o, wr_addr_o, wr_data_o);
    end
    tick();
    vectors++;
    if (wr_en_o !== 1'b1 || wr_addr_o !== 6'd23 || wr_data_o !== 64'h333) begin
      miscompares++;
      $display("FAIL rr_src3_second: got en=%b addr=%0d data=%h want 1/23/333",
               wr_en_o, wr_addr_o, wr_data_o);
    end
    $display("test_contention done");
  endtask

  task automatic test_full_fifo;
    int d0, d1, j;
    int exp0, exp1, exp2;
    logic [NUM_SRC-1:0] acc;
    do_reset();
    d0 = 0; d1 = 0; j = 0;
    exp0 = 0; exp1 = 0; exp2 = 0;
    for (int cyc = 0; cyc < 60; cyc++) begin
      src_valid_i    = '0;
      src_valid_i[0] = (cyc < 20);
      src_valid_i[1] = (cyc < 20);
      src_valid_i[2] = (j < 5);
      src_addr_i[0]  = 6'd1; src_data_i[0] = 64'(d0);
      src_addr_i[1]  = 6'd2; src_data_i[1] = 64'h100 + 64'(d1);
      src_addr_i[2]  = 6'd3; src_data_i[2] = 64'h200 + 64'(j);
      if (cyc == 1) begin
        vectors++;
        if (src_ready_o[2] !== 1'b1) begin
          miscompares++;
          $display("FAIL full_ready_after1: got %b want 1", src_ready_o[2]);
        end
      end
      if (cyc == 2) begin
        vectors++;
        if (src_ready_o[2] !== 1'b0) begin
          miscompares++;
          $display("FAIL full_ready_after2: got %b want 0", src_ready_o[2]);
        end
      end
      acc = src_valid_i & src_ready_o;
      tick();
      if (acc[0]) d0++;
      if (acc[1]) d1++;
      if (acc[2]) j++;
      if (wr_en_o === 1'b1) begin
        vectors++;
        case (wr_addr_o)
          6'd1: begin
            if (wr_data_o !== 64'(exp0)) begin
              miscompares++;
              $display("FAIL full_src0_seq: got %h want %h", wr_data_o, 64'(exp0));
            end
            exp0++;
          end
          6'd2: begin
            if (wr_data_o !== 64'h100 + 64'(exp1)) begin
              miscompares++;
              $display("FAIL full_src1_seq: got %h want %h", wr_data_o, 64'h100 + 64'(exp1));
            end
            exp1++;
          end
          6'd3: begin
            if (wr_data_o !== 64'h200 + 64'(exp2)) begin
              miscompares++;
              $display("FAIL full_src2_seq: got %h want %h", wr_data_o, 64'h200 + 64'(exp2));
            end
            exp2++;
          end
          default: begin
            miscompares++;
            $display("FAIL full_bad_addr: got %0d want 1..3", wr_addr_o);
          end
        endcase
      end
    end
    clear_inputs();
    vectors++;
    if (exp2 != 5 || j != 5) begin
      miscompares++;
      $display("FAIL full_src2_count: got writes=%0d accepts=%0d want 5/5", exp2, j);
    end
    vectors++;
    if (exp0 != d0 || exp1 != d1 || d0 == 0 || d1 == 0) begin
      miscompares++;
      $display("FAIL full_no_loss: got wr0=%0d acc0=%0d wr1=%0d acc1=%0d want equal nonzero",
               exp0, d0, exp1, d1);
    end
    vectors++;
    if (busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL full_drained: got busy=%b want 0", busy_o);
    end
    $display("test_full_fifo done");
  endtask

  task automatic test_x0_fp;
    do_reset();
    src_valid_i[1] = 1'b1; src_addr_i[1] = 6'd0; src_data_i[1] = 64'hFF;
    tick();
    clear_inputs();
    tick();
    vectors++;
    if (wr_en_o !== 1'b0 || busy_o !== 1'b0 || src_ready_o !== 4'hF) begin
      miscompares++;
      $display("FAIL x0_no_write: got en=%b busy=%b ready=%b want 0/0/1111",
               wr_en_o, busy_o, src_ready_o);
    end
    src_valid_i[1] = 1'b1; src_addr_i[1] = 6'd33; src_data_i[1] = 64'hDEAD_BEEF_1234_5678;
    tick();
    clear_inputs();
    tick();
    vectors++;
    if (wr_en_o !== 1'b1 || wr_addr_o !== 6'd33 || wr_data_o !== 64'h0000_0000_1234_5678) begin
      miscompares++;
      $display("FAIL fp_width: got en=%b addr=%0d data=%h want 1/33/0000000012345678",
               wr_en_o, wr_addr_o, wr_data_o);
    end
    src_valid_i[1] = 1'b1; src_addr_i[1] = 6'd7; src_data_i[1] = 64'hDEAD_BEEF_1234_5678;
    tick();
    clear_inputs();
    tick();
    vectors++;
    if (wr_en_o !== 1'b1 || wr_addr_o !== 6'd7 || wr_data_o !== 64'hDEAD_BEEF_1234_5678) begin
      miscompares++;
      $display("FAIL int_width: got en=%b addr=%0d data=%h want 1/7/deadbeef12345678",
               wr_en_o, wr_addr_o, wr_data_o);
    end
    $display("test_x0_fp done");
  endtask

  task automatic test_mid_reset;
    do_reset();
    for (int k = 0; k < NUM_SRC; k++) begin
      src_valid_i[k] = 1'b1;
      src_addr_i[k]  = 6'(k + 40);
      src_data_i[k]  = 64'h500 + 64'(k);
    end
    repeat (2) tick();
    clear_inputs();
    tick();
    vectors++;
    if (wr_en_o !== 1'b1 || wr_addr_o !== 6'd41) begin
      miscompares++;
      $display("FAIL midrst_pre: got en=%b addr=%0d want 1/41", wr_en_o, wr_addr_o);
    end
    arst_ni = 1'b0;
    #1;
    vectors++;
    if (wr_en_o !== 1'b0 || busy_o !== 1'b0 || src_ready_o !== 4'hF) begin
      miscompares++;
      $display("FAIL midrst_async: got en=%b busy=%b ready=%b want 0/0/1111",
               wr_en_o, busy_o, src_ready_o);
    end
    @(posedge clk_i);
    #3;
    arst_ni = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      vectors++;
      if (wr_en_o !== 1'b0 || busy_o !== 1'b0) begin
        miscompares++;
        $display("FAIL midrst_stale[%0d]: got en=%b busy=%b want 0/0", c, wr_en_o, busy_o);
      end
    end
    src_valid_i[1] = 1'b1; src_addr_i[1] = 6'd12; src_data_i[1] = 64'hC;
    src_valid_i[0] = 1'b1; src_addr_i[0] = 6'd11; src_data_i[0] = 64'hB;
    tick();
    clear_inputs();
    tick();
    vectors++;
    if (wr_en_o !== 1'b1 || wr_addr_o !== 6'd11 || wr_data_o !== 64'hB) begin
      miscompares++;
      $display("FAIL midrst_src0_first: got en=%b addr=%0d data=%h want 1/11/b",
               wr_en_o, wr_addr_o, wr_data_o);
    end
    tick();
    vectors++;
    if (wr_en_o !== 1'b1 || wr_addr_o !== 6'd12 || wr_data_o !== 64'hC) begin
      miscompares++;
      $display("FAIL midrst_src1_next: got en=%b addr=%0d data=%h want 1/12/c",
               wr_en_o, wr_addr_o, wr_data_o);
    end
    $display("test_mid_reset done");
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    arst_ni     = 1'b0;
    clear_inputs();
    test_reset();
    test_contention();
    test_full_fifo();
    test_x0_fp();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rv_g_wb_arbiter.md
# rv_g_wb_arbiter

Writeback arbiter between the execution units and the unified integer/FP register file. It buffers results from `NUM_SRC` execution units in small per-source FIFOs and selects at most one result per cycle with round-robin arbitration. It drives the register file's single write-and-unlock port (`wr_en`/`wr_addr`/`wr_data`). It writes registered values only: no combinational path from any `src_*_i` input to any `wr_*_o` output.

## Interface
- `NUM_SRC`, default 4: number of execution-unit result ports; must be at least 2.
- `XLEN`, default 64: integer register width.
- `FLEN`, default 32: floating-point register width.
- `MaxLen`, localparam = max(`FLEN`, `XLEN`): data width.
- `FIFO_DEPTH`, default 2: entries per source FIFO; must be a power of 2, at least 2.
- `arst_ni` input, 1 bit: asynchronous global reset, active-low.
- `clk_i` input, 1 bit: clock.
- `src_valid_i` input, [NUM_SRC]: result valid, one bit per source.
- `src_ready_o` output, [NUM_SRC]: source FIFO can accept a result.
- `src_addr_i` input, [NUM_SRC][5:0]: destination address. Bit 5 set selects an FP register; bit 5 clear selects an integer register.
- `src_data_i` input, [NUM_SRC][MaxLen-1:0]: result data.
- `wr_en_o` output, 1 bit: write-and-unlock enable to the register file.
- `wr_addr_o` output, 6 bits: write address.
- `wr_data_o` output, MaxLen bits: write data.
- `busy_o` output, 1 bit: at least one FIFO is non-empty or `wr_en_o` is high.

## Operation
- **Accept:** a source result is enqueued when `src_valid_i[k] & src_ready_o[k]`.
  - `src_ready_o[k] = ~full[k]`, computed from registered state only.
  - A FIFO that is full does not accept a new result in the same cycle it dequeues.
- **Ordering:** each FIFO is in-order, so results from one source are written in acceptance order.
- **Integer x0:** a result with address 6'd0 is dequeued normally but produces no write (`wr_en_o` stays 0). It still consumes its arbitration slot.
- **FP width rule:** when `src_addr_i[5]=1`, bits [MaxLen-1:FLEN] of the data are forced to 0 before enqueue.
- **Integer width rule:** when `src_addr_i[5]=0`, bits [MaxLen-1:XLEN] are forced to 0. This applies only when FLEN > XLEN.
- **Arbitration:**
  - A register `rr_ptr` holds the index of the last granted source.
  - Each cycle, the grant goes to the first non-empty FIFO searching `rr_ptr+1`, `rr_ptr+2`, … modulo `NUM_SRC`.
  - The winner's head entry is dequeued and `rr_ptr` is set to the winner.
  - If no FIFO is non-empty, `rr_ptr` holds.
- **Output register:** on a grant, the output register loads `wr_en_o = (addr != 0)`, `wr_addr_o = addr` and `wr_data_o = data`. When there is no grant, `wr_en_o` is loaded with 0.
  - `wr_addr_o` and `wr_data_o` hold their last value when `wr_en_o = 0`.
- **No backpressure from the register file:** a write is always accepted and unlocks that address in the same cycle.
- **Per-FIFO state:** read pointer, write pointer and an occupancy count of `$clog2(FIFO_DEPTH)+1` bits. Pointers wrap modulo `FIFO_DEPTH`.

## Timing
- **Reset values:**
  - All FIFOs empty.
  - `src_ready_o` = all ones.
  - `wr_en_o`, `wr_addr_o`, `wr_data_o` = 0.
  - `busy_o` = 0.
  - `rr_ptr` = NUM_SRC-1, so source 0 wins first.
- **Latency:** a result accepted at edge N produces `wr_en_o=1` after edge N+1 at the earliest, i.e. it is visible in cycle N+1. This holds when its FIFO was empty and it wins arbitration.
- **Throughput:** one write per cycle total. A single source streaming continuously sustains one result per cycle when `FIFO_DEPTH` ≥ 2.
- **Fairness:** under continuous contention among `M` active sources, each source is granted exactly once every `M` cycles.
- **Boundary behaviour:**
  - Full FIFO: `src_ready_o[k]=0` until the cycle after a dequeue.
  - Empty FIFO: it never wins arbitration.
  - Pointer wrap-around is transparent to ordering.
- **Reset mid-operation:** asserting `arst_ni` low asynchronously clears all state and outputs. Buffered results are discarded, with no partial write. After reset, `src_ready_o` returns to 1 immediately (combinationally from the cleared state).

## Test plan
1. **Reset:** hold reset, then release. Required: `src_ready_o` all 1, `wr_en_o=0`, `busy_o=0`. Then src0 sends addr 6'd5, data 64'hA5 at edge 0. Required: `wr_en_o=1`, `wr_addr_o=5`, `wr_data_o=64'hA5` in cycle 1 only.
2. **Contention:** all 4 sources present one result in the same cycle (addr 1..4). Required: writes in order src0, src1, src2, src3 on 4 consecutive cycles. Then src3 and src1 present again together. Required: src1 is written first, because `rr_ptr` = 3.
3. **Full FIFO:** src2 is valid for 5 back-to-back cycles while src0 and src1 are continuously busy. Required:
   - `src_ready_o[2]` drops to 0 after 2 accepts.
   - No result is lost or reordered.
   - The src2 write sequence matches its accept order exactly.
4. **x0 and FP width:** src1 sends addr 6'd0, data 64'hFF. Required: no `wr_en_o` pulse, and the FIFO drains. src1 then sends addr 6'd33, data 64'hDEAD_BEEF_1234_5678 with FLEN=32. Required: `wr_addr_o=33`, `wr_data_o=64'h0000_0000_1234_5678`.
5. **Reset mid-operation:** fill all FIFOs, then assert reset for 1 cycle mid-drain. Required: `wr_en_o=0` immediately and no stale write after release. A new result is written with latency 1 and with src0 given first priority.
